// File: rtl/bcd_scan_decoder_if.sv
// Handshake bundle between a packed-word producer and the BCD scan decoder,
// plus the error-flag side channel exposed to the consumer.
interface bcd_scan_decoder_if #(
  parameter int DIGITS = 4,
  parameter int RADIX  = 10,
  parameter int DW     = 4,
  parameter int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DIGITS*DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [RADIX-1:0]     out_onehot;
  logic [IW-1:0]        out_idx;
  logic                 out_err;
  logic                 out_last;
  logic                 err_sticky;
  logic                 err_clr;
  logic [7:0]           err_count;

  // Producer/sink side: drives words, ready and clear.
  modport master (
    output in_valid, in_data, out_ready, err_clr,
    input  in_ready, out_valid, out_onehot, out_idx, out_err, out_last,
           err_sticky, err_count
  );

  // Decoder side.
  modport slave (
    input  in_valid, in_data, out_ready, err_clr,
    output in_ready, out_valid, out_onehot, out_idx, out_err, out_last,
           err_sticky, err_count
  );
endinterface

// File: rtl/bcd_scan_decoder.sv
// Sequential multi-digit BCD decoder: one accepted word is emitted one digit per
// beat, LSD first, as a one-hot vector with a per-digit error flag and error stats.
module bcd_scan_decoder #(
  parameter int DIGITS = 4,
  parameter int RADIX  = 10,
  parameter int DW     = 4,
  parameter int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_scan_decoder_if.slave   bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DIGITS*DW-1:0] word_q, word_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [7:0]           err_count_q, err_count_d;

  logic [DW-1:0]        digit_s;
  logic [RADIX-1:0]     onehot_s;
  logic                 digit_err_s;
  logic                 last_s;
  logic                 out_valid_s;
  logic                 in_ready_s;
  logic                 out_beat_s;
  logic                 in_hs_s;
  logic                 error_beat_s;

  function automatic logic [RADIX-1:0] onehot_of(input logic [DW-1:0] v);
    logic [RADIX-1:0] r;
    r = '0;
    for (int d = 0; d < RADIX; d++) begin
      r[d] = (int'(v) == d);
    end
    return r;
  endfunction

  function automatic logic is_bad_digit(input logic [DW-1:0] v);
    return (int'(v) >= RADIX);
  endfunction

  // Decode of the presented digit and the handshake qualifiers.
  always_comb begin
    digit_s      = word_q[int'(idx_q)*DW +: DW];
    digit_err_s  = is_bad_digit(digit_s);
    onehot_s     = digit_err_s ? '0 : onehot_of(digit_s);
    last_s       = (idx_q == LAST_IDX);
    out_valid_s  = (state_q == S_SCAN);
    // out_ready feeds in_ready combinationally so back-to-back words never bubble.
    in_ready_s   = (state_q == S_IDLE) | (out_valid_s & last_s & bus.out_ready);
    out_beat_s   = out_valid_s & bus.out_ready;
    in_hs_s      = bus.in_valid & in_ready_s;
    error_beat_s = out_beat_s & digit_err_s;
  end

  // Next-state, digit index and word register update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        if (in_hs_s) begin
          word_d  = bus.in_data;
          idx_d   = '0;
          state_d = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (out_beat_s) begin
          if (last_s) begin
            if (bus.in_valid) begin
              word_d  = bus.in_data;
              idx_d   = '0;
              state_d = S_SCAN;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = S_SCAN;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Sticky flag and saturating counter; a set in the clear cycle wins.
  always_comb begin
    err_sticky_d = error_beat_s | (err_sticky_q & ~bus.err_clr);
    if (bus.err_clr) begin
      err_count_d = error_beat_s ? 8'd1 : 8'd0;
    end else if (error_beat_s && (err_count_q != 8'd255)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      word_q       <= '0;
      err_sticky_q <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_s;
  assign bus.out_onehot = onehot_s;
  assign bus.out_idx    = idx_q;
  assign bus.out_err    = digit_err_s;
  assign bus.out_last   = last_s;
  assign bus.err_sticky = err_sticky_q;
  assign bus.err_count  = err_count_q;

endmodule

// File: doc/bcd_scan_decoder.md
# bcd_scan_decoder

Parametrised, sequential successor to the team's single-digit BCD-to-one-hot decoder. It accepts a packed multi-digit word over a valid/ready handshake and emits one decoded digit per accepted beat, least significant digit first, as a one-hot vector with a per-digit error flag. It also keeps a sticky error flag and a saturating error counter. It sits between the numeric datapath and multiplexed display/indicator drivers.

## Interface
- DIGITS, 4: digits per input word; at least 1.
- RADIX, 10: legal digit values 0..RADIX-1; one-hot output width.
- DW, 4: bits per digit; 2^DW >= RADIX is required.
- IW, max(1, clog2(DIGITS)): width of the digit index.

- clk  in  1  sole clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  DIGITS*DW  packed digits; digit k is at bits [k*DW +: DW].
- out_valid  out  1  decoded digit is presented.
- out_ready  in  1  sink accepts the current beat.
- out_onehot  out  RADIX  bit d is set for digit value d; all zero on error.
- out_idx  out  IW  index of the presented digit.
- out_err  out  1  presented digit is >= RADIX.
- out_last  out  1  presented digit is index DIGITS-1.
- err_sticky  out  1  at least one error beat has completed since the last clear.
- err_clr  in  1  clears err_sticky and err_count.
- err_count  out  8  error beats completed, saturating at 255.

## Operation
- Terminology: an input handshake is in_valid & in_ready; an output beat is out_valid & out_ready. An error beat is an output beat with out_err=1.
- FSM states:
  - IDLE:
    - out_valid=0, in_ready=1.
    - On an input handshake: latch in_data into the word register, set idx=0, go to SCAN.
  - SCAN:
    - out_valid=1.
    - The presented digit is word[idx*DW +: DW].
    - On an output beat with idx<DIGITS-1: idx increments.
    - On an output beat with idx==DIGITS-1:
      - If in_valid is also high: accept the new word in the same cycle, idx=0, stay in SCAN.
      - Otherwise: go to IDLE.
- in_ready = (state==IDLE) | (state==SCAN & idx==DIGITS-1 & out_ready). This is a combinational out_ready-to-in_ready path and is permitted.
- Digit decode (combinational from the registered word and idx):
  - Value v < RADIX: out_onehot = 1<<v, out_err=0.
  - Otherwise: out_onehot=0, out_err=1.
- out_last = (idx==DIGITS-1). out_idx = idx.
- Backpressure: while out_valid & !out_ready, out_onehot, out_idx, out_err and out_last hold stable. The word register is written only on an input handshake.
- Error flag:
  - Next err_sticky = error_beat | (err_sticky & ~err_clr).
  - If an error beat and err_clr occur in the same cycle, the set wins.
- Error counter:
  - If err_clr: next err_count = error_beat ? 1 : 0.
  - Otherwise: err_count increments on each error beat and saturates at 255 (no wrap).
- When DIGITS==1, every beat is last; idx is held at 0.

## Timing
- Reset, on the first rising edge with rst_n=0:
  - state=IDLE, idx=0, word=0, err_sticky=0, err_count=0.
  - Therefore out_valid=0, out_onehot=10'b00_0000_0001 (digit 0 of the zeroed word, shown with out_valid low), out_err=0, out_last=(DIGITS==1), out_idx=0, in_ready=1.
- Reset mid-scan: the in-flight word is discarded and no out_last beat is produced.
- Latency:
  - A word accepted at edge N presents digit 0 with out_valid=1 from edge N+1.
  - With out_ready held high, one word takes DIGITS cycles.
  - Back-to-back words incur no idle cycle.
- in_valid may rise and fall freely. No combinational path exists from in_valid or in_data to any out_* signal.

## Test plan
- Decode order, RADIX=10, DIGITS=4: in_data=16'h9051 with out_ready=1. Expect four beats:
  - idx0: 10'b00_0000_0010
  - idx1: 10'b00_0010_0000
  - idx2: 10'b00_0000_0001
  - idx3: 10'b10_0000_0000, with out_last=1
  - All beats out_err=0; IDLE follows.
- Errors: in_data=16'h0A3F.
  - Beats idx0 and idx2 show out_err=1 with out_onehot=0.
  - Afterwards err_sticky=1 and err_count=2.
- Backpressure: 16'h1234 with out_ready low for 3 cycles at idx1. Expect idx1 (digit 3, 10'b00_0000_1000) held stable across all three cycles, in_ready=0, then the sequence resumes unchanged.
- Back-to-back: in_valid held high with words 16'h1111 then 16'h2222, out_ready=1. Expect 8 consecutive beats with no gap; in_ready=1 only on the cycle of the idx3 beat.
- Clear race and saturation:
  - 64 words of 16'hFFFF: err_count reaches 255 and holds.
  - err_clr asserted during an error beat: err_count=1 and err_sticky=1.
  - err_clr asserted with no error beat: err_count=0 and err_sticky=0.
- Reset mid-scan: assert rst_n=0 for one edge during idx2 of 16'h5678. Expect out_valid=0 and in_ready=1 afterwards; no idx3 beat ever appears; a new word then starts at idx0.
